sign_narrow: RTL and testbench
==============================

SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  producer presents a word.
REQ-004 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-005 SHALL have port in_data  input  32  word to narrow.
REQ-006 SHALL have port in_unsigned  input  1  1: treat in_data as zero-extended; 0: as sign-extended; sampled with in_data.
REQ-007 SHALL have port out_valid  output  1  narrowed result available.
REQ-008 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port out_data  output  16  narrowed halfword.
REQ-010 SHALL have port out_ovf  output  1  the word in out_data did not fit in 16 bits.
REQ-011 SHALL have port ovf_count  output  8  number of accepted overflowing words; saturates at 8'hFF.

Function
REQ-012 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready, at the rising edge.
REQ-013 SHALL hold results in a 2-entry in-order buffer; in_ready = (occupancy < 2), derived from registered state only, never from out_ready.
REQ-014 SHALL present an accepted word on out_data/out_ovf in the cycle after acceptance when the buffer was empty (latency 1); no bypass.
REQ-015 SHALL allow accept and pop in the same cycle; occupancy is unchanged, and order is preserved.
REQ-016 SHALL, with occupancy 2, ignore in_valid (no accept) even when out_ready is high that cycle.
REQ-017 SHALL hold out_data, out_ovf and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL flag a signed overflow when in_data[31:15] is not all-equal, and an unsigned overflow when in_data[31:16] != 0.
REQ-019 SHALL, without saturation, produce out_data = in_data[15:0] regardless of overflow.
REQ-020 SHALL increment ovf_count on each accepted overflowing word; the count holds at 8'hFF; it is unaffected by pops.
REQ-021 SHALL drive out_data = 16'h0000 and out_ovf = 0 whenever out_valid = 0.

Reset
REQ-022 SHALL, while reset = 1 at a clock edge, clear occupancy, out_valid, out_data, out_ovf and ovf_count to 0; in_ready reads 0 while reset is asserted.
REQ-023 SHALL discard buffered words on reset mid-operation; no partial output after reset is released.
REQ-024 SHALL raise in_ready in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL compile saturation in only when SIGN_NARROW_SAT_EN is defined: overflowing signed input yields 16'h7FFF (in_data[31]=0) or 16'h8000 (in_data[31]=1), and overflowing unsigned input yields 16'hFFFF; out_ovf is still set.
REQ-026 SHALL, with SIGN_NARROW_SAT_EN undefined, behave per REQ-019; all other behaviour is identical in both builds.

Verification
REQ-027 SHALL cover: reset; then in_valid=1, in_data=32'hFFFF_FFFE, in_unsigned=0, out_ready=1 -> next cycle out_data=16'hFFFE, out_ovf=0.
REQ-028 SHALL cover: signed 32'h0000_8000 -> out_ovf=1, ovf_count=1; out_data=16'h8000 (no SAT), 16'h7FFF (SAT_EN).
REQ-029 SHALL cover: unsigned 32'h0000_FFFF -> out_ovf=0, out_data=16'hFFFF; unsigned 32'h0001_0000 -> out_ovf=1, out_data=16'h0000 (no SAT) or 16'hFFFF (SAT_EN).
REQ-030 SHALL cover: out_ready=0, push 32'h1, 32'h2, 32'h3 back to back -> in_ready low after second accept, third held; release out_ready -> outputs 1, 2, 3 in order.
REQ-031 SHALL cover: 300 accepted overflowing words -> ovf_count=8'hFF, not wrapped.
REQ-032 SHALL cover: reset asserted with 2 entries buffered -> next cycle out_valid=0, ovf_count=0, and no stale outputs after release.

Source files
------------

// File: rtl/sign_narrow.sv
// sign_narrow: narrows 32-bit words to 16 bits through a 2-entry in-order buffer,
// flagging overflow. Define SIGN_NARROW_SAT_EN to saturate overflowing results.
//
// occupancy | meaning
// 0         | empty, outputs forced to zero
// 1         | slot0 holds the head result
// 2         | slot0 head, slot1 next; input stalls
module sign_narrow (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic [7:0]  ovf_count
);

  logic [1:0]  occ, occ_nxt;
  logic [15:0] data0, data1;
  logic        ovf0, ovf1;
  logic        push, pop;
  logic        w_ovf;
  logic [15:0] w_data;

  always_comb begin
    if (in_unsigned) w_ovf = |in_data[31:16];
    else             w_ovf = !((&in_data[31:15]) || !(|in_data[31:15]));
`ifdef SIGN_NARROW_SAT_EN
    if (!w_ovf)           w_data = in_data[15:0];
    else if (in_unsigned) w_data = 16'hFFFF;
    else if (in_data[31]) w_data = 16'h8000;
    else                  w_data = 16'h7FFF;
`else
    w_data = in_data[15:0];
`endif
  end

  assign in_ready  = !reset && (occ < 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? data0 : 16'h0000;
  assign out_ovf   = out_valid & ovf0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) occ <= 2'd0;
    else       occ <= occ_nxt;
  end

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + 2'd1;
    else if (pop && !push) occ_nxt = occ - 2'd1;
  end

  // Slot0 is always the head; on a pop with occupancy 2 the tail shifts forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      data0 <= 16'h0000;
      ovf0  <= 1'b0;
      data1 <= 16'h0000;
      ovf1  <= 1'b0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            data0 <= w_data;
            ovf0  <= w_ovf;
          end
        end
        2'd1: begin
          if (push && pop) begin
            data0 <= w_data;
            ovf0  <= w_ovf;
          end else if (push) begin
            data1 <= w_data;
            ovf1  <= w_ovf;
          end
        end
        2'd2: begin
          if (pop) begin
            data0 <= data1;
            ovf0  <= ovf1;
          end
        end
        default: begin
          data0 <= data0;
          ovf0  <= ovf0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                   ovf_count <= 8'h00;
    else if (push && w_ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
  end

endmodule

// File: tb/tb_sign_narrow.sv
// tb_sign_narrow: directed and randomized checks of sign_narrow against a queue-based
// reference model; honours SIGN_NARROW_SAT_EN when defined.
module tb_sign_narrow;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_unsigned, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_data;
  logic [7:0]  ovf_count;

  typedef struct {
    logic [15:0] d;
    logic        o;
  } ent_t;

  ent_t q[$];
  int   m_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  sign_narrow dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_unsigned(in_unsigned),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  function automatic ent_t ref_narrow(logic [31:0] w, logic u);
    ent_t   e;
    longint sv;
    sv = longint'($signed(w));
    if (u) e.o = (w > 32'h0000_FFFF);
    else   e.o = (sv > 32767) || (sv < -32768);
    e.d = w[15:0];
`ifdef SIGN_NARROW_SAT_EN
    if (e.o) e.d = u ? 16'hFFFF : ((sv < 0) ? 16'h8000 : 16'h7FFF);
`endif
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(!reset && q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_data", 32'(out_data), (q.size() > 0) ? 32'(q[0].d) : 32'h0);
    chk("out_ovf", 32'(out_ovf), (q.size() > 0) ? 32'(q[0].o) : 32'h0);
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
  endtask

  task automatic step(logic r, logic v, logic [31:0] d, logic u, logic ordy);
    logic do_push, do_pop;
    ent_t e;
    reset = r; in_valid = v; in_data = d; in_unsigned = u; out_ready = ordy;
    do_push = !r && v && (q.size() < 2);
    do_pop  = (q.size() > 0) && ordy;
    e = ref_narrow(d, u);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        if (e.o && m_cnt < 255) m_cnt++;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] pick_word();
    logic [31:0] w;
    case ($urandom_range(0, 4))
      0: w = $urandom;
      1: w = {{16{1'b0}}, 16'($urandom)};
      2: w = {{16{1'b1}}, 16'($urandom)};
      3: begin
        case ($urandom_range(0, 5))
          0: w = 32'h0000_7FFF;
          1: w = 32'h0000_8000;
          2: w = 32'hFFFF_8000;
          3: w = 32'hFFFF_7FFF;
          4: w = 32'h0001_0000;
          default: w = 32'h0000_FFFF;
        endcase
      end
      default: w = {{15{1'b0}}, 17'($urandom)};
    endcase
    return w;
  endfunction

  initial begin
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);

    // simple signed in-range word, latency 1
    step(0, 1, 32'hFFFF_FFFE, 0, 1);
    chk("req027_data", 32'(out_data), 32'h0000_FFFE);
    step(0, 0, 32'h0, 0, 1);

    step(0, 1, 32'h0000_8000, 0, 1);
    chk("req028_ovf", 32'(out_ovf), 32'h1);
    chk("req028_cnt", 32'(ovf_count), 32'h1);
    step(0, 1, 32'h0000_FFFF, 1, 1);
    chk("req029a_ovf", 32'(out_ovf), 32'h0);
    step(0, 1, 32'h0001_0000, 1, 1);
    chk("req029b_ovf", 32'(out_ovf), 32'h1);
    step(0, 0, 32'h0, 0, 1);

    // backpressure: third word must be held until space frees
    step(0, 1, 32'h1, 0, 0);
    step(0, 1, 32'h2, 0, 0);
    chk("req030_stall", 32'(in_ready), 32'h0);
    step(0, 1, 32'h3, 0, 0);
    chk("req030_head", 32'(out_data), 32'h1);
    step(0, 1, 32'h3, 0, 1);
    chk("req030_second", 32'(out_data), 32'h2);
    step(0, 1, 32'h3, 0, 1);
    chk("req030_third", 32'(out_data), 32'h3);
    step(0, 0, 32'h0, 0, 1);

    for (int i = 0; i < 300; i++) step(0, 1, 32'h1234_0000 + 32'(i), 0, 1);
    chk("req031_sat", 32'(ovf_count), 32'hFF);
    step(0, 0, 32'h0, 0, 1);

    step(0, 1, 32'h0002_0000, 0, 0);
    step(0, 1, 32'h0003_0000, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    chk("req032_valid", 32'(out_valid), 32'h0);
    chk("req032_cnt", 32'(ovf_count), 32'h0);
    step(0, 0, 32'h0, 0, 1);
    chk("req024_ready", 32'(in_ready), 32'h1);
    step(0, 0, 32'h0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), pick_word(),
           1'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
